// File: rtl/lc3_mmio_pkg.sv
// Shared constants for the LC-3 memory-mapped I/O responder: device addresses and status bit positions.
package lc3_mmio_pkg;

    localparam int unsigned MMIO_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [MMIO_W-1:0] ADDR_KBSR = 16'hFE00;
    localparam logic [MMIO_W-1:0] ADDR_KBDR = 16'hFE02;
    localparam logic [MMIO_W-1:0] ADDR_DSR  = 16'hFE04;
    localparam logic [MMIO_W-1:0] ADDR_DDR  = 16'hFE06;
    localparam logic [MMIO_W-1:0] ADDR_MCR  = 16'hFFFE;

    localparam int unsigned BIT_READY = 15;
    localparam int unsigned BIT_IE    = 14;
    localparam int unsigned BIT_OVR   = 1;

    // Assemble a device status word from its three flag bits; all other bits read as zero.
    function automatic logic [MMIO_W-1:0] status_word(input logic rdy, input logic ie, input logic ovr);
        logic [MMIO_W-1:0] w;
        w            = '0;
        w[BIT_READY] = rdy;
        w[BIT_IE]    = ie;
        w[BIT_OVR]   = ovr;
        return w;
    endfunction

endpackage

// File: rtl/lc3_mmio_responder_if.sv
// CPU memory-bus, keyboard and display signals seen by the MMIO responder.
interface lc3_mmio_responder_if;
    import lc3_mmio_pkg::*;

    logic              mem_en;
    logic              mem_we;
    logic [MMIO_W-1:0] mar;
    logic [MMIO_W-1:0] wdata;
    logic              mmio_hit;
    logic [MMIO_W-1:0] rdata;
    logic              resp_valid;
    logic              kb_valid;
    logic [BYTE_W-1:0] kb_data;
    logic              kb_ready;
    logic              dsp_valid;
    logic [BYTE_W-1:0] dsp_data;
    logic              dsp_ready;
    logic              kb_irq;
    logic              dsp_irq;
    logic              run;

    modport master (
        output mem_en, mem_we, mar, wdata, kb_valid, kb_data, dsp_ready,
        input  mmio_hit, rdata, resp_valid, kb_ready, dsp_valid, dsp_data, kb_irq, dsp_irq, run
    );

    modport slave (
        input  mem_en, mem_we, mar, wdata, kb_valid, kb_data, dsp_ready,
        output mmio_hit, rdata, resp_valid, kb_ready, dsp_valid, dsp_data, kb_irq, dsp_irq, run
    );

endinterface

// File: rtl/lc3_byte_fifo.sv
// Small byte FIFO for keyboard input; simultaneous push and pop are both honoured.
module lc3_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       empty_nxt,
    output logic [7:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Next-state: pops and pushes qualified by the current occupancy, pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push & ~full_q;
        do_pop   = pop & ~empty_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State registers; reset flushes the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = empty_d;
    assign head      = mem_q[rd_ptr_q];

endmodule

// File: rtl/lc3_mmio_responder.sv
// LC-3 memory-mapped I/O responder: keyboard, display and machine-control registers.
module lc3_mmio_responder
    import lc3_mmio_pkg::*;
#(
    parameter int unsigned KB_DEPTH = 4,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    lc3_mmio_responder_if.slave  bus
);

    logic              sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, sel_mcr, hit;
    logic              rd, wr, hs, ddr_accept;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_empty_nxt;
    logic [BYTE_W-1:0] fifo_head;
    logic              unused_wdata;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              kb_ie_q, kb_ie_d;
    logic [BYTE_W-1:0] last_kb_q, last_kb_d;
    logic              rdy_q, rdy_d;
    logic              dsp_ie_q, dsp_ie_d;
    logic              ovr_q, ovr_d;
    logic              dsp_valid_q, dsp_valid_d;
    logic [BYTE_W-1:0] dsp_data_q, dsp_data_d;
    logic              run_q, run_d;
    logic              kb_irq_q, kb_irq_d;
    logic              dsp_irq_q, dsp_irq_d;

    assign unused_wdata = ^bus.wdata[13:8];

    assign fifo_push = bus.kb_valid & ~fifo_full;

    lc3_byte_fifo #(.DEPTH(KB_DEPTH)) u_kb_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (bus.kb_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .empty_nxt (fifo_empty_nxt),
        .head      (fifo_head)
    );

    // Address decode, read mux, write side effects and display handshake.
    always_comb begin
        sel_kbsr = bus.mem_en && (bus.mar == ADDR_KBSR);
        sel_kbdr = bus.mem_en && (bus.mar == ADDR_KBDR);
        sel_dsr  = bus.mem_en && (bus.mar == ADDR_DSR);
        sel_ddr  = bus.mem_en && (bus.mar == ADDR_DDR);
        sel_mcr  = bus.mem_en && (bus.mar == ADDR_MCR);
        hit      = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr | sel_mcr;
        rd       = hit & ~bus.mem_we;
        wr       = hit & bus.mem_we;

        rdata_d      = rdata_q;
        resp_valid_d = hit;
        kb_ie_d      = kb_ie_q;
        last_kb_d    = last_kb_q;
        rdy_d        = rdy_q;
        dsp_ie_d     = dsp_ie_q;
        ovr_d        = ovr_q;
        dsp_valid_d  = dsp_valid_q;
        dsp_data_d   = dsp_data_q;
        run_d        = run_q;

        fifo_pop   = sel_kbdr & ~bus.mem_we & ~fifo_empty;
        hs         = dsp_valid_q & bus.dsp_ready;
        ddr_accept = rdy_q | hs;

        if (hs) begin
            dsp_valid_d = 1'b0;
            rdy_d       = 1'b1;
        end

        if (rd) begin
            if (sel_kbsr)      rdata_d = status_word(~fifo_empty, kb_ie_q, 1'b0);
            else if (sel_kbdr) rdata_d = {8'h00, (fifo_empty ? last_kb_q : fifo_head)};
            else if (sel_dsr)  rdata_d = status_word(rdy_q, dsp_ie_q, ovr_q);
            else if (sel_ddr)  rdata_d = {8'h00, dsp_data_q};
            else               rdata_d = {run_q, 15'b0};
        end

        if (fifo_pop) last_kb_d = fifo_head;

        if (wr) begin
            if (sel_kbsr) kb_ie_d = bus.wdata[BIT_IE];
            if (sel_dsr) begin
                dsp_ie_d = bus.wdata[BIT_IE];
                ovr_d    = 1'b0;
            end
            if (sel_ddr) begin
                if (ddr_accept) begin
                    dsp_data_d  = bus.wdata[BYTE_W-1:0];
                    dsp_valid_d = 1'b1;
                    rdy_d       = 1'b0;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            if (sel_mcr) run_d = bus.wdata[15];
        end

        kb_irq_d  = ~fifo_empty_nxt & kb_ie_d;
        dsp_irq_d = rdy_d & dsp_ie_d;
    end

    // Register bank and response register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            kb_ie_q      <= 1'b0;
            last_kb_q    <= '0;
            rdy_q        <= 1'b1;
            dsp_ie_q     <= 1'b0;
            ovr_q        <= 1'b0;
            dsp_valid_q  <= 1'b0;
            dsp_data_q   <= '0;
            run_q        <= 1'b1;
            kb_irq_q     <= 1'b0;
            dsp_irq_q    <= 1'b0;
        end else begin
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            kb_ie_q      <= kb_ie_d;
            last_kb_q    <= last_kb_d;
            rdy_q        <= rdy_d;
            dsp_ie_q     <= dsp_ie_d;
            ovr_q        <= ovr_d;
            dsp_valid_q  <= dsp_valid_d;
            dsp_data_q   <= dsp_data_d;
            run_q        <= run_d;
            kb_irq_q     <= kb_irq_d;
            dsp_irq_q    <= dsp_irq_d;
        end
    end

    assign bus.mmio_hit   = hit;
    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.kb_ready   = ~fifo_full;
    assign bus.dsp_valid  = dsp_valid_q;
    assign bus.dsp_data   = dsp_data_q;
    assign bus.kb_irq     = kb_irq_q;
    assign bus.dsp_irq    = dsp_irq_q;
    assign bus.run        = run_q;

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// Directed self-checking bench for lc3_mmio_responder.
module tb_lc3_mmio_responder;
    import lc3_mmio_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    lc3_mmio_responder_if bus ();

    lc3_mmio_responder #(.KB_DEPTH(4), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic we, input logic [15:0] addr, input logic [15:0] data);
        bus.mem_en = 1'b1;
        bus.mem_we = we;
        bus.mar    = addr;
        bus.wdata  = data;
        tick();
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        acc(1'b0, addr, 16'h0000);
        check_eq(tag, bus.rdata, exp);
        check_eq({tag, "_rv"}, 16'(bus.resp_valid), 16'h0001);
    endtask

    task automatic kb_push(input logic [7:0] b);
        bus.kb_valid = 1'b1;
        bus.kb_data  = b;
        tick();
        bus.kb_valid = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mar       = 16'h0000;
        bus.wdata     = 16'h0000;
        bus.kb_valid  = 1'b0;
        bus.kb_data   = 8'h00;
        bus.dsp_ready = 1'b0;

        // Reset
        repeat (3) tick();
        check_eq("rst_run", 16'(bus.run), 16'h0001);
        check_eq("rst_dsp_valid", 16'(bus.dsp_valid), 16'h0000);
        check_eq("rst_rdata", bus.rdata, 16'h0000);
        check_eq("rst_resp_valid", 16'(bus.resp_valid), 16'h0000);
        rst_n = 1'b1;
        tick();
        rd("rst_dsr", ADDR_DSR, 16'h8000);
        rd("rst_kbsr", ADDR_KBSR, 16'h0000);
        tick();
        check_eq("rv_pulse", 16'(bus.resp_valid), 16'h0000);
        check_eq("rdata_hold", bus.rdata, 16'h0000);

        // Keyboard basic
        kb_push(8'h41);
        kb_push(8'h42);
        rd("kb_kbsr_ne", ADDR_KBSR, 16'h8000);
        rd("kb_rd1", ADDR_KBDR, 16'h0041);
        rd("kb_rd2", ADDR_KBDR, 16'h0042);
        rd("kb_rd3_empty", ADDR_KBDR, 16'h0042);
        rd("kb_kbsr_e", ADDR_KBSR, 16'h0000);
        acc(1'b1, ADDR_KBDR, 16'h00FF);
        check_eq("kbdr_wr_rv", 16'(bus.resp_valid), 16'h0001);
        rd("kbdr_wr_ignored", ADDR_KBDR, 16'h0042);

        // FIFO full, held-off push, simultaneous push/pop
        kb_push(8'h43);
        kb_push(8'h44);
        kb_push(8'h45);
        kb_push(8'h46);
        check_eq("full_kb_ready", 16'(bus.kb_ready), 16'h0000);
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'h47;
        tick();
        check_eq("held_kb_ready", 16'(bus.kb_ready), 16'h0000);
        rd("full_rd", ADDR_KBDR, 16'h0043);
        check_eq("after_pop_ready", 16'(bus.kb_ready), 16'h0001);
        tick();
        bus.kb_valid = 1'b0;
        check_eq("refill_full", 16'(bus.kb_ready), 16'h0000);
        rd("ord_44", ADDR_KBDR, 16'h0044);
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'h48;
        rd("simul_rd", ADDR_KBDR, 16'h0045);
        bus.kb_valid = 1'b0;
        check_eq("simul_cnt3", 16'(bus.kb_ready), 16'h0001);
        kb_push(8'h49);
        check_eq("simul_cnt4", 16'(bus.kb_ready), 16'h0000);
        rd("ord_46", ADDR_KBDR, 16'h0046);
        rd("ord_47", ADDR_KBDR, 16'h0047);
        rd("ord_48", ADDR_KBDR, 16'h0048);
        rd("ord_49", ADDR_KBDR, 16'h0049);
        bus.kb_valid = 1'b1;
        bus.kb_data  = 8'h4A;
        rd("pop_empty_push", ADDR_KBDR, 16'h0049);
        bus.kb_valid = 1'b0;
        rd("pushed_stays", ADDR_KBSR, 16'h8000);
        rd("pushed_byte", ADDR_KBDR, 16'h004A);

        // Keyboard interrupt
        acc(1'b1, ADDR_KBSR, 16'h4000);
        check_eq("kb_irq_empty", 16'(bus.kb_irq), 16'h0000);
        rd("kbsr_ie", ADDR_KBSR, 16'h4000);
        kb_push(8'h50);
        check_eq("kb_irq_set", 16'(bus.kb_irq), 16'h0001);
        rd("kb_irq_rd", ADDR_KBDR, 16'h0050);
        check_eq("kb_irq_clr", 16'(bus.kb_irq), 16'h0000);
        acc(1'b1, ADDR_KBSR, 16'h0000);

        // Display
        acc(1'b1, ADDR_DDR, 16'h0158);
        check_eq("dsp_valid", 16'(bus.dsp_valid), 16'h0001);
        check_eq("dsp_data", 16'(bus.dsp_data), 16'h0058);
        rd("dsr_busy", ADDR_DSR, 16'h0000);
        acc(1'b1, ADDR_DDR, 16'h0123);
        rd("dsr_ovr", ADDR_DSR, 16'h0002);
        check_eq("dsp_data_stable", 16'(bus.dsp_data), 16'h0058);
        bus.dsp_ready = 1'b1;
        tick();
        bus.dsp_ready = 1'b0;
        check_eq("hs_valid_clr", 16'(bus.dsp_valid), 16'h0000);
        rd("dsr_rdy_ovr", ADDR_DSR, 16'h8002);
        acc(1'b1, ADDR_DSR, 16'h4000);
        check_eq("dsp_irq_set", 16'(bus.dsp_irq), 16'h0001);
        rd("dsr_ie", ADDR_DSR, 16'hC000);
        acc(1'b1, ADDR_DDR, 16'h0061);
        check_eq("dsp_irq_busy", 16'(bus.dsp_irq), 16'h0000);
        bus.dsp_ready = 1'b1;
        acc(1'b1, ADDR_DDR, 16'h0062);
        bus.dsp_ready = 1'b0;
        check_eq("hs_accept_valid", 16'(bus.dsp_valid), 16'h0001);
        check_eq("hs_accept_data", 16'(bus.dsp_data), 16'h0062);
        rd("hs_accept_dsr", ADDR_DSR, 16'h4000);
        rd("ddr_read", ADDR_DDR, 16'h0062);
        bus.dsp_ready = 1'b1;
        tick();
        bus.dsp_ready = 1'b0;
        check_eq("dsp_irq_done", 16'(bus.dsp_irq), 16'h0001);
        acc(1'b1, ADDR_DSR, 16'h0000);
        check_eq("dsp_irq_off", 16'(bus.dsp_irq), 16'h0000);

        // MCR and unmapped access
        rd("mcr_run", ADDR_MCR, 16'h8000);
        acc(1'b1, ADDR_MCR, 16'h0000);
        check_eq("run_clr", 16'(bus.run), 16'h0000);
        rd("mcr_halt", ADDR_MCR, 16'h0000);
        bus.mem_en = 1'b1;
        bus.mem_we = 1'b0;
        bus.mar    = ADDR_KBSR;
        #1;
        check_eq("hit_mapped", 16'(bus.mmio_hit), 16'h0001);
        bus.mar = 16'hFE08;
        #1;
        check_eq("hit_unmapped", 16'(bus.mmio_hit), 16'h0000);
        tick();
        bus.mem_en = 1'b0;
        check_eq("unmapped_rv", 16'(bus.resp_valid), 16'h0000);
        check_eq("unmapped_rdata", bus.rdata, 16'h0000);

        // Reset mid-handshake
        kb_push(8'h70);
        acc(1'b1, ADDR_DDR, 16'h0033);
        check_eq("pre_rst_valid", 16'(bus.dsp_valid), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 16'(bus.dsp_valid), 16'h0000);
        check_eq("mid_rst_run", 16'(bus.run), 16'h0001);
        check_eq("mid_rst_data", 16'(bus.dsp_data), 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("mid_rst_kb_ready", 16'(bus.kb_ready), 16'h0001);
        rd("mid_rst_kbsr", ADDR_KBSR, 16'h0000);
        rd("mid_rst_dsr", ADDR_DSR, 16'h8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
